// File: rtl/trap_sequencer.sv
// Trap and return sequencer: synchronises the external interrupt, arbitrates
// exceptions, mret and interrupts, and drives CSR strobes plus PC redirect requests.
module trap_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_irq,
    input  logic        frc_cntr_val_leq,
    input  logic        csr_rmie,
    input  logic        csr_meie,
    input  logic        csr_mtie,
    input  logic        cpu_stat_pc,
    input  logic        cpu_stat_ex,
    input  logic        illegal_ops_ex,
    input  logic        cmd_ecall_ex,
    input  logic        cmd_ebreak_ex,
    input  logic        cmd_mret_ex,
    input  logic        pc_redirect_ack,
    output logic        g_interrupt,
    output logic        g_interrupt_1shot,
    output logic [1:0]  g_interrupt_priv,
    output logic        interrupts_in_pc_state,
    output logic        g_exception,
    output logic        trap_redirect,
    output logic        mret_redirect,
    output logic        pipe_flush,
    output logic [15:0] trap_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PC,
        ENTER,
        REDIR,
        RET_REDIR
    } state_t;

    state_t      state_q;
    logic        sync1_q;
    logic        sync2_q;
    logic        prev_q;
    logic        irq_strobe_q;
    logic        exc_strobe_q;
    logic        trap_redir_q;
    logic        mret_redir_q;
    logic        flush_q;
    logic [15:0] trap_cnt_q;

    logic        int_pend;
    logic        exc_ev;
    logic        ret_ev;

    // Two flops for metastability, a third only to find the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= ext_irq;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign int_pend = (sync2_q & csr_meie) | (frc_cntr_val_leq & csr_mtie);
    assign exc_ev   = cpu_stat_ex & (illegal_ops_ex | cmd_ecall_ex | cmd_ebreak_ex);
    assign ret_ev   = cpu_stat_ex & cmd_mret_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            irq_strobe_q <= 1'b0;
            exc_strobe_q <= 1'b0;
            trap_redir_q <= 1'b0;
            mret_redir_q <= 1'b0;
            flush_q      <= 1'b0;
            trap_cnt_q   <= 16'h0000;
        end else begin
            irq_strobe_q <= 1'b0;
            exc_strobe_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (exc_ev) begin
                        state_q      <= REDIR;
                        trap_redir_q <= 1'b1;
                        flush_q      <= 1'b1;
                        exc_strobe_q <= illegal_ops_ex;
                    end else if (ret_ev) begin
                        state_q      <= RET_REDIR;
                        mret_redir_q <= 1'b1;
                        flush_q      <= 1'b1;
                    end else if (int_pend && csr_rmie) begin
                        state_q <= WAIT_PC;
                    end
                end
                // An exception here abandons the interrupt; IDLE re-evaluates it later.
                WAIT_PC: begin
                    if (exc_ev) begin
                        state_q      <= REDIR;
                        trap_redir_q <= 1'b1;
                        flush_q      <= 1'b1;
                        exc_strobe_q <= illegal_ops_ex;
                    end else if (!int_pend || !csr_rmie) begin
                        state_q <= IDLE;
                    end else if (cpu_stat_pc) begin
                        state_q      <= ENTER;
                        irq_strobe_q <= 1'b1;
                    end
                end
                ENTER: begin
                    state_q      <= REDIR;
                    trap_redir_q <= 1'b1;
                    flush_q      <= 1'b1;
                end
                REDIR: begin
                    if (pc_redirect_ack) begin
                        state_q      <= IDLE;
                        trap_redir_q <= 1'b0;
                        flush_q      <= 1'b0;
                        trap_cnt_q   <= trap_cnt_q + 16'h0001;
                    end
                end
                RET_REDIR: begin
                    if (pc_redirect_ack) begin
                        state_q      <= IDLE;
                        mret_redir_q <= 1'b0;
                        flush_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    trap_redir_q <= 1'b0;
                    mret_redir_q <= 1'b0;
                    flush_q      <= 1'b0;
                end
            endcase
        end
    end

    assign g_interrupt            = sync2_q;
    assign g_interrupt_1shot      = sync2_q & ~prev_q;
    assign g_interrupt_priv       = 2'b11;
    assign interrupts_in_pc_state = irq_strobe_q;
    assign g_exception            = exc_strobe_q;
    assign trap_redirect          = trap_redir_q;
    assign mret_redirect          = mret_redir_q;
    assign pipe_flush             = flush_q;
    assign trap_cnt               = trap_cnt_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: scenario tasks with a trap_cnt
// scoreboard filled when a trap is stimulated and drained when it is acked.
module tb_trap_sequencer;

    logic        clk;
    logic        rst_n;
    logic        ext_irq;
    logic        frc_cntr_val_leq;
    logic        csr_rmie;
    logic        csr_meie;
    logic        csr_mtie;
    logic        cpu_stat_pc;
    logic        cpu_stat_ex;
    logic        illegal_ops_ex;
    logic        cmd_ecall_ex;
    logic        cmd_ebreak_ex;
    logic        cmd_mret_ex;
    logic        pc_redirect_ack;
    logic        g_interrupt;
    logic        g_interrupt_1shot;
    logic [1:0]  g_interrupt_priv;
    logic        interrupts_in_pc_state;
    logic        g_exception;
    logic        trap_redirect;
    logic        mret_redirect;
    logic        pipe_flush;
    logic [15:0] trap_cnt;

    int          checks = 0;
    int          failures = 0;
    int          irqSeen = 0;
    int          excSeen = 0;
    int          overlapSeen = 0;
    logic [15:0] expCnt = 16'h0000;
    logic [15:0] expQ[$];

    trap_sequencer dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ext_irq                (ext_irq),
        .frc_cntr_val_leq       (frc_cntr_val_leq),
        .csr_rmie               (csr_rmie),
        .csr_meie               (csr_meie),
        .csr_mtie               (csr_mtie),
        .cpu_stat_pc            (cpu_stat_pc),
        .cpu_stat_ex            (cpu_stat_ex),
        .illegal_ops_ex         (illegal_ops_ex),
        .cmd_ecall_ex           (cmd_ecall_ex),
        .cmd_ebreak_ex          (cmd_ebreak_ex),
        .cmd_mret_ex            (cmd_mret_ex),
        .pc_redirect_ack        (pc_redirect_ack),
        .g_interrupt            (g_interrupt),
        .g_interrupt_1shot      (g_interrupt_1shot),
        .g_interrupt_priv       (g_interrupt_priv),
        .interrupts_in_pc_state (interrupts_in_pc_state),
        .g_exception            (g_exception),
        .trap_redirect          (trap_redirect),
        .mret_redirect          (mret_redirect),
        .pipe_flush             (pipe_flush),
        .trap_cnt               (trap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobes last a full cycle, so one negedge sample counts each pulse once.
    always @(negedge clk) begin
        if (interrupts_in_pc_state) irqSeen++;
        if (g_exception) excSeen++;
        if (interrupts_in_pc_state && g_exception) overlapSeen++;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog simulation did not finish got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({g_interrupt, g_interrupt_1shot, interrupts_in_pc_state, g_exception,
             trap_redirect, mret_redirect, pipe_flush} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got %b want 0000000", {g_interrupt,
                     g_interrupt_1shot, interrupts_in_pc_state, g_exception,
                     trap_redirect, mret_redirect, pipe_flush});
        end
        checks++;
        if (trap_cnt !== 16'h0000 || g_interrupt_priv !== 2'b11) begin
            failures++;
            $display("[TB] FAIL reset_cnt_priv got %h/%b want 0000/11", trap_cnt, g_interrupt_priv);
        end
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_ext_irq;
        logic [15:0] e;
        csr_rmie = 1'b1;
        csr_meie = 1'b1;
        cpu_stat_pc = 1'b1;
        ext_irq = 1'b1;
        expCnt = expCnt + 16'h0001;
        expQ.push_back(expCnt);
        tick(1);
        checks++;
        if (g_interrupt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sync_early got %b want 0", g_interrupt);
        end
        tick(1);
        checks++;
        if (g_interrupt !== 1'b1 || g_interrupt_1shot !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sync_rise got %b%b want 11", g_interrupt, g_interrupt_1shot);
        end
        tick(1);
        checks++;
        if (g_interrupt_1shot !== 1'b0 || interrupts_in_pc_state !== 1'b0) begin
            failures++;
            $display("[TB] FAIL oneshot_wait got %b%b want 00", g_interrupt_1shot, interrupts_in_pc_state);
        end
        tick(1);
        checks++;
        if (interrupts_in_pc_state !== 1'b1 || trap_redirect !== 1'b0) begin
            failures++;
            $display("[TB] FAIL irq_enter got %b%b want 10", interrupts_in_pc_state, trap_redirect);
        end
        csr_rmie = 1'b0;
        tick(1);
        checks++;
        if (trap_redirect !== 1'b1 || pipe_flush !== 1'b1 || interrupts_in_pc_state !== 1'b0) begin
            failures++;
            $display("[TB] FAIL irq_redir got %b%b%b want 110", trap_redirect, pipe_flush,
                     interrupts_in_pc_state);
        end
        tick(2);
        checks++;
        if (trap_redirect !== 1'b1) begin
            failures++;
            $display("[TB] FAIL irq_hold got %b want 1", trap_redirect);
        end
        pc_redirect_ack = 1'b1;
        tick(1);
        pc_redirect_ack = 1'b0;
        ext_irq = 1'b0;
        checks++;
        if (trap_redirect !== 1'b0 || pipe_flush !== 1'b0) begin
            failures++;
            $display("[TB] FAIL irq_drop got %b%b want 00", trap_redirect, pipe_flush);
        end
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL irq_sb got empty want entry");
        end else begin
            e = expQ.pop_front();
            if (trap_cnt !== e) begin
                failures++;
                $display("[TB] FAIL irq_cnt got %h want %h", trap_cnt, e);
            end
        end
        csr_meie = 1'b0;
        cpu_stat_pc = 1'b0;
        tick(4);
    endtask

    task automatic test_timer_mask;
        logic [15:0] e;
        int snap;
        int leaked;
        leaked = 0;
        snap = irqSeen;
        csr_rmie = 1'b1;
        csr_mtie = 1'b0;
        frc_cntr_val_leq = 1'b1;
        cpu_stat_pc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (trap_redirect !== 1'b0 || interrupts_in_pc_state !== 1'b0) leaked++;
        end
        checks++;
        if (leaked != 0 || irqSeen != snap) begin
            failures++;
            $display("[TB] FAIL timer_masked got %0d strobes want 0", leaked + irqSeen - snap);
        end
        csr_mtie = 1'b1;
        expCnt = expCnt + 16'h0001;
        expQ.push_back(expCnt);
        tick(2);
        checks++;
        if (interrupts_in_pc_state !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timer_enter got %b want 1", interrupts_in_pc_state);
        end
        csr_rmie = 1'b0;
        frc_cntr_val_leq = 1'b0;
        csr_mtie = 1'b0;
        tick(1);
        checks++;
        if (trap_redirect !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timer_redir got %b want 1", trap_redirect);
        end
        pc_redirect_ack = 1'b1;
        tick(1);
        pc_redirect_ack = 1'b0;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL timer_sb got empty want entry");
        end else begin
            e = expQ.pop_front();
            if (trap_cnt !== e || trap_redirect !== 1'b0) begin
                failures++;
                $display("[TB] FAIL timer_cnt got %h/%b want %h/0", trap_cnt, trap_redirect, e);
            end
        end
        cpu_stat_pc = 1'b0;
        tick(3);
    endtask

    task automatic test_exc_preempt;
        logic [15:0] e;
        int snapIrq;
        int snapExc;
        csr_rmie = 1'b1;
        csr_meie = 1'b1;
        cpu_stat_pc = 1'b0;
        ext_irq = 1'b1;
        tick(6);
        snapIrq = irqSeen;
        snapExc = excSeen;
        cpu_stat_ex = 1'b1;
        illegal_ops_ex = 1'b1;
        expCnt = expCnt + 16'h0001;
        expQ.push_back(expCnt);
        tick(1);
        cpu_stat_ex = 1'b0;
        illegal_ops_ex = 1'b0;
        ext_irq = 1'b0;
        csr_rmie = 1'b0;
        checks++;
        if (g_exception !== 1'b1 || trap_redirect !== 1'b1 || pipe_flush !== 1'b1 ||
            interrupts_in_pc_state !== 1'b0) begin
            failures++;
            $display("[TB] FAIL exc_entry got %b%b%b%b want 1110", g_exception, trap_redirect,
                     pipe_flush, interrupts_in_pc_state);
        end
        tick(1);
        checks++;
        if (g_exception !== 1'b0 || trap_redirect !== 1'b1) begin
            failures++;
            $display("[TB] FAIL exc_pulse got %b%b want 01", g_exception, trap_redirect);
        end
        pc_redirect_ack = 1'b1;
        tick(1);
        pc_redirect_ack = 1'b0;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL exc_sb got empty want entry");
        end else begin
            e = expQ.pop_front();
            if (trap_cnt !== e) begin
                failures++;
                $display("[TB] FAIL exc_cnt got %h want %h", trap_cnt, e);
            end
        end
        tick(4);
        checks++;
        if (irqSeen != snapIrq || excSeen != snapExc + 1) begin
            failures++;
            $display("[TB] FAIL exc_strobes got irq=%0d exc=%0d want irq=0 exc=1",
                     irqSeen - snapIrq, excSeen - snapExc);
        end
        csr_meie = 1'b0;
    endtask

    task automatic test_cancel_mret;
        logic [15:0] e;
        int snapIrq;
        int bad;
        bad = 0;
        snapIrq = irqSeen;
        csr_rmie = 1'b1;
        csr_meie = 1'b1;
        cpu_stat_pc = 1'b0;
        ext_irq = 1'b1;
        tick(6);
        ext_irq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (trap_redirect || mret_redirect || pipe_flush || g_exception) bad++;
        end
        cpu_stat_pc = 1'b1;
        tick(3);
        checks++;
        if (bad != 0 || irqSeen != snapIrq || trap_redirect !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cancel got bad=%0d strobes=%0d want 0/0", bad, irqSeen - snapIrq);
        end
        cpu_stat_pc = 1'b0;
        cpu_stat_ex = 1'b1;
        cmd_mret_ex = 1'b1;
        expQ.push_back(expCnt);
        tick(1);
        cpu_stat_ex = 1'b0;
        cmd_mret_ex = 1'b0;
        checks++;
        if (mret_redirect !== 1'b1 || pipe_flush !== 1'b1 || trap_redirect !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mret_entry got %b%b%b want 110", mret_redirect, pipe_flush, trap_redirect);
        end
        tick(2);
        checks++;
        if (mret_redirect !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mret_hold got %b want 1", mret_redirect);
        end
        pc_redirect_ack = 1'b1;
        tick(1);
        pc_redirect_ack = 1'b0;
        checks++;
        if (mret_redirect !== 1'b0 || pipe_flush !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mret_drop got %b%b want 00", mret_redirect, pipe_flush);
        end
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL mret_sb got empty want entry");
        end else begin
            e = expQ.pop_front();
            if (trap_cnt !== e) begin
                failures++;
                $display("[TB] FAIL mret_cnt got %h want %h", trap_cnt, e);
            end
        end
        csr_rmie = 1'b0;
        csr_meie = 1'b0;
        tick(2);
    endtask

    task automatic test_back_to_back;
        logic [15:0] e;
        for (int k = 0; k < 3; k++) begin
            cpu_stat_ex = 1'b1;
            if (k == 1) cmd_ebreak_ex = 1'b1;
            else cmd_ecall_ex = 1'b1;
            expCnt = expCnt + 16'h0001;
            expQ.push_back(expCnt);
            tick(1);
            cpu_stat_ex = 1'b0;
            cmd_ecall_ex = 1'b0;
            cmd_ebreak_ex = 1'b0;
            checks++;
            if (trap_redirect !== 1'b1 || g_exception !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_entry%0d got %b%b want 10", k, trap_redirect, g_exception);
            end
            pc_redirect_ack = 1'b1;
            tick(1);
            pc_redirect_ack = 1'b0;
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL b2b_sb%0d got empty want entry", k);
            end else begin
                e = expQ.pop_front();
                if (trap_cnt !== e || trap_redirect !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL b2b_cnt%0d got %h/%b want %h/0", k, trap_cnt, trap_redirect, e);
                end
            end
        end
        tick(2);
    endtask

    task automatic test_wrap_stray;
        logic [15:0] e;
        force dut.trap_cnt_q = 16'hFFFF;
        #1;
        release dut.trap_cnt_q;
        expCnt = 16'hFFFF;
        tick(1);
        pc_redirect_ack = 1'b1;
        tick(1);
        pc_redirect_ack = 1'b0;
        tick(1);
        checks++;
        if (trap_cnt !== 16'hFFFF || trap_redirect !== 1'b0 || mret_redirect !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stray_ack got %h/%b%b want ffff/00", trap_cnt, trap_redirect, mret_redirect);
        end
        cpu_stat_ex = 1'b1;
        cmd_ecall_ex = 1'b1;
        expCnt = expCnt + 16'h0001;
        expQ.push_back(expCnt);
        tick(1);
        cpu_stat_ex = 1'b0;
        cmd_ecall_ex = 1'b0;
        pc_redirect_ack = 1'b1;
        tick(1);
        pc_redirect_ack = 1'b0;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL wrap_sb got empty want entry");
        end else begin
            e = expQ.pop_front();
            if (trap_cnt !== e) begin
                failures++;
                $display("[TB] FAIL wrap_cnt got %h want %h", trap_cnt, e);
            end
        end
        tick(2);
    endtask

    task automatic test_reset_redir;
        int bad;
        bad = 0;
        cpu_stat_ex = 1'b1;
        cmd_ecall_ex = 1'b1;
        tick(1);
        cpu_stat_ex = 1'b0;
        cmd_ecall_ex = 1'b0;
        checks++;
        if (trap_redirect !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_pre got %b want 1", trap_redirect);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({g_interrupt, g_interrupt_1shot, interrupts_in_pc_state, g_exception, trap_redirect,
             mret_redirect, pipe_flush} !== 7'b0 || trap_cnt !== 16'h0000 ||
            g_interrupt_priv !== 2'b11) begin
            failures++;
            $display("[TB] FAIL rst_mid got %b/%h/%b want 0000000/0000/11", {g_interrupt,
                     g_interrupt_1shot, interrupts_in_pc_state, g_exception, trap_redirect,
                     mret_redirect, pipe_flush}, trap_cnt, g_interrupt_priv);
        end
        expCnt = 16'h0000;
        expQ.delete();
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (trap_redirect || pipe_flush || mret_redirect || trap_cnt !== 16'h0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL rst_idle got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        ext_irq = 1'b0;
        frc_cntr_val_leq = 1'b0;
        csr_rmie = 1'b0;
        csr_meie = 1'b0;
        csr_mtie = 1'b0;
        cpu_stat_pc = 1'b0;
        cpu_stat_ex = 1'b0;
        illegal_ops_ex = 1'b0;
        cmd_ecall_ex = 1'b0;
        cmd_ebreak_ex = 1'b0;
        cmd_mret_ex = 1'b0;
        pc_redirect_ack = 1'b0;
        #2;
        test_reset();
        test_ext_irq();
        test_timer_mask();
        test_exc_preempt();
        test_cancel_mret();
        test_back_to_back();
        test_wrap_stray();
        test_reset_redir();
        checks++;
        if (overlapSeen != 0) begin
            failures++;
            $display("[TB] FAIL strobe_overlap got %0d want 0", overlapSeen);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Trap and return sequencer in front of the CSR array. It synchronises the external interrupt line, qualifies pending interrupts against the enable bits, and picks a winner when exceptions and interrupts collide. It then drives the one-cycle strobes the CSR array latches on, plus a held redirect request to the PC stage for trap entry (mtvec) and `mret` (mepc). The block sits between the EX stage, the interrupt sources and the PC/fetch control. Privilege is M-mode only.

## Interface
- No parameters.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ext_irq`  in  1  raw external interrupt level, asynchronous to `clk`.
- `frc_cntr_val_leq`  in  1  timer-compare pending level, synchronous to `clk`.
- `csr_rmie`  in  1  mstatus.MIE.
- `csr_meie`  in  1  mie.MEIE.
- `csr_mtie`  in  1  mie.MTIE.
- `cpu_stat_pc`  in  1  pipeline is at the PC-state safe point.
- `cpu_stat_ex`  in  1  EX stage holds a valid instruction.
- `illegal_ops_ex`  in  1  illegal instruction in EX.
- `cmd_ecall_ex`  in  1  ecall in EX.
- `cmd_ebreak_ex`  in  1  ebreak in EX.
- `cmd_mret_ex`  in  1  mret in EX.
- `pc_redirect_ack`  in  1  one-cycle acknowledge from the PC stage.
- `g_interrupt`  out  1  synchronised external interrupt level.
- `g_interrupt_1shot`  out  1  rising-edge pulse of `g_interrupt`.
- `g_interrupt_priv`  out  2  target privilege; constant 2'b11.
- `interrupts_in_pc_state`  out  1  one-cycle interrupt-accept strobe.
- `g_exception`  out  1  one-cycle illegal-op exception strobe.
- `trap_redirect`  out  1  request: load PC from mtvec.
- `mret_redirect`  out  1  request: load PC from mepc.
- `pipe_flush`  out  1  kill younger instructions.
- `trap_cnt`  out  16  count of traps taken.

## Operation
- **Synchroniser.**
  - `ext_irq` passes through a 2-flop synchroniser; the output is `g_interrupt`.
  - A third flop is used for edge detect: `g_interrupt_1shot = g_interrupt & ~prev`.
- **Pending.** `int_pend = (g_interrupt & csr_meie) | (frc_cntr_val_leq & csr_mtie)`.
- **Synchronous events.**
  - `exc_ev = cpu_stat_ex & (illegal_ops_ex | cmd_ecall_ex | cmd_ebreak_ex)`.
  - `ret_ev = cpu_stat_ex & cmd_mret_ex`.
- **Priority.** `exc_ev` > `ret_ev` > interrupt.
- **FSM states.** IDLE, WAIT_PC, ENTER, REDIR, RET_REDIR.
- **IDLE**
  - `exc_ev` → REDIR. `g_exception` pulses this cycle only if `illegal_ops_ex`.
  - `ret_ev` → RET_REDIR.
  - `int_pend & csr_rmie` → WAIT_PC.
- **WAIT_PC**
  - `exc_ev` → REDIR. The interrupt is abandoned and re-evaluated later from IDLE.
  - `~int_pend | ~csr_rmie` → IDLE. This cancels a spurious request with no strobe.
  - `cpu_stat_pc` → ENTER.
- **ENTER:** `interrupts_in_pc_state = 1` for exactly this cycle; unconditionally → REDIR.
- **REDIR**
  - `trap_redirect = 1` and `pipe_flush = 1`, both held.
  - On `pc_redirect_ack` → IDLE, and `trap_cnt` increments.
- **RET_REDIR**
  - `mret_redirect = 1` and `pipe_flush = 1`, both held.
  - On `pc_redirect_ack` → IDLE.
- **Ignored events.** Events arriving in ENTER, REDIR or RET_REDIR are ignored, because the pipeline is being flushed.
- **`trap_cnt`.** 16-bit, wraps 16'hFFFF → 16'h0000. It counts exception traps and interrupt traps; mret is not counted.
- **Stray ack.** `pc_redirect_ack` received in IDLE, WAIT_PC or ENTER is ignored.
- **Reset mid-operation.**
  - The FSM returns to IDLE and all outputs clear at once.
  - A pending request is dropped. The PC stage must also be reset, so no ack is owed.

## Timing
- **Reset values**
  - `g_interrupt`, `g_interrupt_1shot`, `interrupts_in_pc_state`, `g_exception`: 0.
  - `trap_redirect`, `mret_redirect`, `pipe_flush`: 0.
  - `trap_cnt`: 0.
  - `g_interrupt_priv`: 2'b11.
  - Synchroniser flops: 0.
- **External interrupt path.**
  - `ext_irq` rising at edge N gives `g_interrupt` high after edge N+2.
  - `g_interrupt_1shot` is high for the single cycle after edge N+2.
- **Interrupt latency.**
  - If `int_pend & csr_rmie` is sampled at edge E: WAIT_PC from E.
  - If `cpu_stat_pc` is already high: ENTER from E+1, `trap_redirect` from E+2.
- **Exception latency.**
  - `exc_ev` sampled at edge E: `trap_redirect` and `pipe_flush` are high from E.
  - The registered `g_exception` is high for the cycle E..E+1 only.
- **Redirect handshake.**
  - The request stays high until the edge where `pc_redirect_ack = 1` is sampled. It drops in the following cycle.
  - The earliest ack is the first cycle the request is high, giving a minimum 1-cycle request.
- **Strobe timing.**
  - `interrupts_in_pc_state` and `g_exception` are registered (Moore).
  - `g_exception` is never high in the same cycle as `interrupts_in_pc_state`.
- **`csr_rmie` feedback.** The CSR array clears `csr_rmie` one cycle after the strobe, so REDIR sees MIE = 0 and cannot re-enter.

## Test plan
- **External interrupt.**
  - Stimulus: `csr_rmie = csr_meie = 1`, `cpu_stat_pc = 1`, `ext_irq` 0→1.
  - Response: `g_interrupt` high 2 cycles later; 1-cycle `g_interrupt_1shot`; `interrupts_in_pc_state` pulse; `trap_redirect` held until ack at +3 cycles; `trap_cnt = 1`.
- **Timer interrupt masked, then enabled.**
  - Stimulus: `frc_cntr_val_leq = 1`, `csr_mtie = 0` for 10 cycles, then set `csr_mtie = 1`.
  - Response: no strobe while masked; WAIT_PC→ENTER once enabled.
- **Exception pre-empts interrupt.**
  - Stimulus: in WAIT_PC with `cpu_stat_pc = 0`, apply `illegal_ops_ex & cpu_stat_ex`.
  - Response: `g_exception` pulse; no `interrupts_in_pc_state`; `trap_redirect` asserted.
- **Cancel and mret.**
  - Stimulus 1: drop `ext_irq` while in WAIT_PC. Response: back to IDLE, no outputs asserted.
  - Stimulus 2: `cmd_mret_ex & cpu_stat_ex`. Response: `mret_redirect` held until ack; `trap_cnt` unchanged.
- **Counter wrap and stray ack.**
  - Stimulus: preload `trap_cnt = 16'hFFFF` by 65535 traps (or force), take one ecall trap.
  - Response: `trap_cnt = 0`.
  - Also: an ack pulsed in IDLE has no effect.
- **Reset in REDIR.**
  - Stimulus: assert `rst_n = 0` while `trap_redirect = 1`.
  - Response: all outputs 0 and `g_interrupt_priv = 2'b11` immediately; IDLE after release.
